// File: rtl/bios_loader.sv
// bios_loader: serial programming front-end for the CPU code memory.
// It parses frames of the form SYNC, COUNT, 2*COUNT data bytes, CHECK from a
// valid/ready byte stream. Data bytes are packed high byte first into 16-bit
// words, and each word is written to the code memory with a one-cycle strobe.
// The CPU is held from SYNC onwards. It is released only when the frame's
// checksum matches.
module bios_loader #(
    parameter int          ADDR_W    = 5,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    // Largest legal word count, at the 9-bit width used to range-check COUNT.
    localparam logic [8:0] CAPACITY = 9'(2 ** ADDR_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_HI,
        S_LO,
        S_WRITE,
        S_CHECK
    } state_t;

    state_t            state;
    logic [7:0]        hi_byte;
    logic [7:0]        sum;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   remaining;

    logic accept;
    logic count_ok;

    // A byte transfers on the edge where both sides agree.
    assign accept = rx_valid && rx_ready;

    // The word count must be 1..capacity. Zero is rejected, and so is any
    // count that would run past the last address.
    assign count_ok = (rx_data != 8'd0) && ({1'b0, rx_data} <= CAPACITY);

    // Frame parser: one registered state machine that also drives every output.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            rx_ready  <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            cpu_hold  <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            sum       <= '0;
            hi_byte   <= '0;
            addr      <= '0;
            remaining <= '0;
        end else begin
            // NOTE: non-blocking assignments let every register see the
            // pre-edge value of the others, e.g. sum and hi_byte in S_LO.
            // Both strobes default low so that each one lasts exactly one cycle.
            wr_en <= 1'b0;
            done  <= 1'b0;

            case (state)
                S_IDLE: begin
                    rx_ready <= 1'b1;
                    // Non-sync bytes are accepted and dropped.
                    if (accept && rx_data == SYNC_BYTE) begin
                        state    <= S_COUNT;
                        cpu_hold <= 1'b1;
                        err      <= 1'b0;
                        addr     <= '0;
                        sum      <= '0;
                    end
                end

                S_COUNT: begin
                    if (accept) begin
                        if (count_ok) begin
                            remaining <= (ADDR_W + 1)'(rx_data);
                            state     <= S_HI;
                        end else begin
                            // A bad count keeps the CPU held, as a bad checksum does.
                            err   <= 1'b1;
                            state <= S_IDLE;
                        end
                    end
                end

                S_HI: begin
                    if (accept) begin
                        hi_byte <= rx_data;
                        state   <= S_LO;
                    end
                end

                S_LO: begin
                    if (accept) begin
                        sum      <= sum + hi_byte + rx_data;
                        wr_en    <= 1'b1;
                        wr_addr  <= addr;
                        wr_data  <= {hi_byte, rx_data};
                        // Input is stalled for the single write cycle.
                        rx_ready <= 1'b0;
                        state    <= S_WRITE;
                    end
                end

                S_WRITE: begin
                    rx_ready  <= 1'b1;
                    remaining <= remaining - 1'b1;
                    if (remaining == (ADDR_W + 1)'(1)) begin
                        // Last word: addr is not advanced, so it never wraps.
                        state <= S_CHECK;
                    end else begin
                        addr  <= addr + 1'b1;
                        state <= S_HI;
                    end
                end

                S_CHECK: begin
                    if (accept) begin
                        // Words already written stay written, whatever the outcome.
                        if (rx_data == sum) begin
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            err <= 1'b1;
                        end
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bios_loader.sv
// Testbench for bios_loader.
// A frame-level model turns each byte list into the expected list of writes and
// the expected err / cpu_hold / done outcome. A monitor compares the DUT with
// that model on every falling edge.
module tb_bios_loader;

    localparam int ADDR_W = 5;
    localparam logic [7:0] SYNC = 8'hA5;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;
    logic              cpu_hold;
    logic              done;
    logic              err;

    bios_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(SYNC)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    always #5 clock = ~clock;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
    } wr_t;

    int   checks = 0;
    int   failures = 0;
    wr_t  exp_q[$];
    wr_t  mon_e;
    int   exp_done = 0;
    int   done_seen = 0;
    int   ready_low = 0;
    logic exp_err = 1'b0;
    logic exp_hold = 1'b0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: locate the sync byte, validate the count, list the
    // words and compare the checksum.
    task automatic model_frame(input bq_t b);
        int i = 0;
        int n;
        logic [7:0] s = 8'h00;
        while (i < b.size() && b[i] != SYNC) i++;
        if (i + 1 >= b.size()) return;
        n = int'(b[i+1]);
        exp_hold = 1'b1;
        if (n == 0 || n > 2 ** ADDR_W) begin
            exp_err = 1'b1;
            return;
        end
        for (int k = 0; k < n; k++) begin
            exp_q.push_back('{addr: ADDR_W'(k), data: {b[i+2+2*k], b[i+3+2*k]}});
            s = s + b[i+2+2*k] + b[i+3+2*k];
        end
        if (b[i+2+2*n] == s) begin
            exp_err  = 1'b0;
            exp_hold = 1'b0;
            exp_done++;
        end else begin
            exp_err = 1'b1;
        end
    endtask

    // Drive bytes on the valid/ready handshake. Call this at a falling edge.
    // gap is the number of idle cycles inserted after each byte.
    task automatic send(input bq_t b, input int gap);
        foreach (b[j]) begin
            int wait_c = 0;
            rx_data  = b[j];
            rx_valid = 1'b1;
            while (!rx_ready && wait_c < 20) begin
                @(negedge clock);
                wait_c++;
            end
            if (!rx_ready) check("rx_ready_timeout", 32'd0, 32'd1);
            @(negedge clock);
            if (gap > 0) begin
                rx_valid = 1'b0;
                repeat (gap) @(negedge clock);
            end
        end
        rx_valid = 1'b0;
    endtask

    // Wait for the frame to drain, then compare the frame outcome with the model.
    task automatic finish_frame(input string tag);
        repeat (3) @(negedge clock);
        check({tag, "_err"}, err, exp_err);
        check({tag, "_cpu_hold"}, cpu_hold, exp_hold);
        check({tag, "_done_count"}, done_seen, exp_done);
        check({tag, "_writes_left"}, exp_q.size(), 0);
    endtask

    // Per-cycle monitor: checks the write stream, the rx_ready/WRITE relation
    // and the done/err exclusion.
    always @(negedge clock) begin
        if (mon_en) begin
            check("rx_ready_vs_wr_en", rx_ready, !wr_en);
            check("done_err_overlap", done && err, 32'd0);
            if (!rx_ready) ready_low++;
            if (done) done_seen++;
            if (wr_en) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("wr_addr", wr_addr, mon_e.addr);
                    check("wr_data", wr_data, mon_e.data);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_rx_ready"}, rx_ready, 32'd0);
        check({tag, "_wr_en"}, wr_en, 32'd0);
        check({tag, "_wr_addr"}, wr_addr, 32'd0);
        check({tag, "_wr_data"}, wr_data, 32'd0);
        check({tag, "_cpu_hold"}, cpu_hold, 32'd0);
        check({tag, "_done"}, done, 32'd0);
        check({tag, "_err"}, err, 32'd0);
    endtask

    task automatic release_reset();
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        mon_en = 1'b1;
    endtask

    initial begin
        bq_t f;

        // Reset state.
        repeat (2) @(negedge clock);
        check_reset_values("reset");
        release_reset();
        check("ready_after_reset", rx_ready, 32'd1);

        // 1: good two-word frame; cpu_hold is checked partway through.
        f = '{8'hA5, 8'h02, 8'hE0, 8'h1E, 8'h00, 8'h00, 8'hFE};
        model_frame(f);
        send(f[0:2], 0);
        check("t1_hold_mid_frame", cpu_hold, 32'd1);
        check("t1_err_mid_frame", err, 32'd0);
        send(f[3:6], 0);
        finish_frame("t1");
        check("t1_lit_done_count", done_seen, 32'd1);
        check("t1_lit_last_addr", wr_addr, 32'd1);
        check("t1_lit_last_data", wr_data, 32'h0000);
        check("t1_lit_hold", cpu_hold, 32'd0);

        // 2: bad checksum, then a good frame clears err.
        f = '{8'hA5, 8'h02, 8'hE0, 8'h1E, 8'h00, 8'h00, 8'h00};
        model_frame(f);
        send(f, 0);
        finish_frame("t2_bad");
        check("t2_lit_err", err, 32'd1);
        check("t2_lit_hold", cpu_hold, 32'd1);
        f = '{8'hA5, 8'h02, 8'hE0, 8'h1E, 8'h00, 8'h00, 8'hFE};
        model_frame(f);
        send(f, 0);
        finish_frame("t2_good");
        check("t2_lit_err_cleared", err, 32'd0);

        // 3: illegal counts 0 and 33, then a stray 00 that must be discarded.
        f = '{8'hA5, 8'h00};
        model_frame(f);
        send(f, 0);
        finish_frame("t3_zero");
        check("t3_lit_err_zero", err, 32'd1);
        f = '{8'hA5, 8'h21};
        model_frame(f);
        send(f, 0);
        finish_frame("t3_big");
        f = '{8'h00};
        model_frame(f);
        send(f, 0);
        finish_frame("t3_discard");

        // 4: leading junk bytes with rx_valid gaps, then a one-word frame.
        f = '{8'h00, 8'hFF, 8'h12, 8'hA5, 8'h01, 8'h12, 8'h34, 8'h46};
        model_frame(f);
        send(f, 1);
        finish_frame("t4");
        check("t4_lit_data", wr_data, 32'h1234);
        check("t4_lit_addr", wr_addr, 32'd0);

        // 5: full-capacity frame of 32 words at full rate.
        f = '{8'hA5, 8'h20};
        begin
            logic [7:0] s = 8'h00;
            for (int j = 0; j < 64; j++) begin
                f.push_back(8'(j * 37 + 5));
                s = s + 8'(j * 37 + 5);
            end
            f.push_back(s);
        end
        model_frame(f);
        ready_low = 0;
        send(f, 0);
        finish_frame("t5");
        check("t5_ready_low_cycles", ready_low, 32'd32);
        check("t5_lit_last_addr", wr_addr, 32'd31);
        check("t5_lit_err", err, 32'd0);

        // 6: reset after the third word of a ten-word frame.
        f = '{8'hA5, 8'h0A, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        exp_q.push_back('{addr: 5'd0, data: 16'h0102});
        exp_q.push_back('{addr: 5'd1, data: 16'h0304});
        exp_q.push_back('{addr: 5'd2, data: 16'h0506});
        send(f, 0);
        @(negedge clock);
        check("t6_hold_before_reset", cpu_hold, 32'd1);
        mon_en  = 1'b0;
        reset_n = 1'b0;
        #1;
        check_reset_values("t6_reset");
        check("t6_writes_left", exp_q.size(), 0);
        exp_err  = 1'b0;
        exp_hold = 1'b0;
        release_reset();
        f = '{8'hA5, 8'h01, 8'hAB, 8'hCD, 8'h78};
        model_frame(f);
        send(f, 0);
        finish_frame("t6");
        check("t6_lit_data", wr_data, 32'hABCD);
        check("t6_lit_addr", wr_addr, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
